// File: rtl/spi_cfg_responder.sv
// SPI mode-0 responder with a small readable/writable configuration register file.
// Optional build macro SPI_CFG_PARITY_EN appends an even-parity bit to every frame.
module spi_cfg_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int NREG        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sel,
    input  logic              cs_b,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

`ifdef SPI_CFG_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int CMD_BITS   = 1 + ADDR_W;
    localparam int RX_W       = DATA_W + PAR_W;
    localparam int FRAME_BITS = CMD_BITS + RX_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2) + 1;
    localparam int IDX_W      = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_BITS);
    localparam logic [ADDR_W:0]   NREG_L    = (ADDR_W + 1)'(NREG);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, sclk_rise, sclk_fall;

    logic [CNT_W-1:0]    cnt;
    logic [CMD_BITS-1:0] cmd_sh;
    logic [RX_W-1:0]     rx_sh;
    logic [RX_W-1:0]     tx_sh;
    logic [RX_W-1:0]     tx_load;
    logic                fall_seen;

    logic [DATA_W-1:0] regs [NREG];

    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic              addr_ok;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rx_data;
    logic              parity_ok;
    logic              frame_ok, frame_bad;

    // Chip select resets low so a frame already in flight when reset lifts is never picked up.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
            cs_sync   <= SYNC_STAGES'({cs_sync, cs_b});
            sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
            mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    assign rw      = cmd_sh[ADDR_W];
    assign addr    = cmd_sh[ADDR_W-1:0];
    assign addr_ok = {1'b0, addr} < NREG_L;
    assign rd_data = addr_ok ? regs[addr[IDX_W-1:0]] : '0;
    assign rx_data = rx_sh[RX_W-1 -: DATA_W];

    assign dbg_data = ({1'b0, dbg_addr} < NREG_L) ? regs[dbg_addr[IDX_W-1:0]] : '0;

`ifdef SPI_CFG_PARITY_EN
    // Even parity over rw, addr, data and the parity bit itself; only writes depend on it.
    assign parity_ok = !rw || !(^{cmd_sh, rx_sh});
    assign tx_load   = {rd_data, ^rd_data};
`else
    assign parity_ok = 1'b1;
    assign tx_load   = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_next = state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: if (spi_sel && cs_fall) state_next = CMD;
            CMD: begin
                if (!spi_sel || cs_s) begin
                    frame_bad  = 1'b1;
                    state_next = IDLE;
                end else if (sclk_rise && cnt == CMD_LAST) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (!spi_sel) begin
                    frame_bad  = 1'b1;
                    state_next = IDLE;
                end else if (cs_s) begin
                    state_next = IDLE;
                    if (cnt == FRAME_END && parity_ok) frame_ok  = 1'b1;
                    else                               frame_bad = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            cmd_sh     <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            fall_seen  <= 1'b0;
            miso       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            // NOTE: the register file is small and must read back 0 after reset, so it is reset explicitly.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            frame_done <= frame_ok;
            frame_err  <= frame_bad;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    fall_seen <= 1'b0;
                    miso      <= 1'b0;
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_sh <= {cmd_sh[CMD_BITS-2:0], mosi_s};
                        cnt    <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    // The counter saturates so long overruns still compare unequal to a full frame.
                    if (sclk_rise) begin
                        rx_sh <= {rx_sh[RX_W-2:0], mosi_s};
                        if (cnt != '1) cnt <= cnt + 1'b1;
                    end
                    if (sclk_fall && !rw) begin
                        fall_seen <= 1'b1;
                        if (!fall_seen) {miso, tx_sh} <= {tx_load, 1'b0};
                        else            {miso, tx_sh} <= {tx_sh, 1'b0};
                    end
                end
                default: ;
            endcase
            if (frame_ok || frame_bad) miso <= 1'b0;
            if (frame_ok) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (rw && addr_ok) regs[addr[IDX_W-1:0]] <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_responder.sv
// Directed bench for spi_cfg_responder: a bit-banged mode-0 initiator pushes expected
// frame outcomes into a scoreboard that a separate monitor checks against the pulses.
module tb_spi_cfg_responder;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 7;
    localparam int CMD_BITS = 1 + ADDR_W;
`ifdef SPI_CFG_PARITY_EN
    localparam int FRAME = CMD_BITS + DATA_W + 1;
`else
    localparam int FRAME = CMD_BITS + DATA_W;
`endif
    localparam int HALF = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_sel;
    logic              cs_b;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              frame_done;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    spi_cfg_responder dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sel    (spi_sel),
        .cs_b       (cs_b),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] cnt;
        bit          is_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_word;
    logic        miso_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input bit is_err, input logic [15:0] cnt,
                                input bit is_rd, input logic [31:0] rd);
        exp_t e;
        e.is_err = is_err;
        e.cnt    = cnt;
        e.is_rd  = is_rd;
        e.rd     = rd;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] mk(input logic rw, input logic [6:0] a, input logic [31:0] d);
        logic [63:0] v;
        v = {24'b0, rw, a, d};
`ifdef SPI_CFG_PARITY_EN
        v = {v[62:0], ^{rw, a, d}};
`endif
        return v;
    endfunction

    // Sends nbits of vec MSB first; drop_at / rst_at (bit index, -1 = never) inject faults.
    task automatic xfer(input logic sel_v, input int nbits, input logic [63:0] vec,
                        input int drop_at, input int rst_at);
        rd_word = '0;
        miso_hi = 1'b0;
        spi_sel = sel_v;
        repeat (4) @(negedge clk);
        cs_b = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_at) spi_sel = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            mosi = vec[nbits-1-i];
            repeat (HALF) @(negedge clk);
            if (i >= CMD_BITS && i < CMD_BITS + DATA_W) rd_word = {rd_word[30:0], miso};
            miso_hi = miso_hi | miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_b = 1'b1;
        mosi = 1'b0;
        repeat (16) @(negedge clk);
        spi_sel = 1'b1;
    endtask

    task automatic peek(input string name, input logic [6:0] a, input logic [31:0] exp);
        dbg_addr = a;
        @(negedge clk);
        check(name, dbg_data, exp);
    endtask

    // Monitor: every frame pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (frame_done || frame_err)) begin
                check("done_err_exclusive", {31'b0, frame_done & frame_err}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b with nothing expected",
                             frame_done, frame_err);
                end else begin
                    e = sb.pop_front();
                    check("pulse_is_err", {31'b0, frame_err}, {31'b0, e.is_err});
                    check("frame_cnt", {16'b0, frame_cnt}, {16'b0, e.cnt});
                    if (e.is_rd) check("read_miso", rd_word, e.rd);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b1; spi_sel = 1'b1; cs_b = 1'b1; sclk = 1'b0; mosi = 1'b0; dbg_addr = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        check("rst_miso", {31'b0, miso}, 32'd0);
        check("rst_done", {31'b0, frame_done}, 32'd0);
        check("rst_err", {31'b0, frame_err}, 32'd0);
        peek("rst_reg3", 7'd3, 32'h0);

        expect_frame(0, 16'd1, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'd3, 32'hA5A5_1234), -1, -1);
        check("write_no_miso", {31'b0, miso_hi}, 32'd0);
        peek("wr_reg3", 7'd3, 32'hA5A5_1234);

        expect_frame(0, 16'd2, 1, 32'hA5A5_1234);
        xfer(1'b1, FRAME, mk(1'b0, 7'd3, 32'h0), -1, -1);
        peek("rd_reg3", 7'd3, 32'hA5A5_1234);

        expect_frame(1, 16'd2, 0, 32'h0);
        xfer(1'b1, 20, mk(1'b1, 7'd3, 32'hFFFF_0000) >> (FRAME - 20), -1, -1);
        peek("abort_reg3", 7'd3, 32'hA5A5_1234);

        expect_frame(1, 16'd2, 0, 32'h0);
        xfer(1'b1, FRAME + 1, mk(1'b1, 7'd1, 32'hDEAD_BEEF) << 1, -1, -1);
        peek("overrun_reg1", 7'd1, 32'h0);

        xfer(1'b0, FRAME, mk(1'b1, 7'd2, 32'h1234_5678), -1, -1);
        check("sel0_miso", {31'b0, miso_hi}, 32'd0);
        peek("sel0_reg2", 7'd2, 32'h0);

        expect_frame(0, 16'd3, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'h50, 32'hCAFE_F00D), -1, -1);
        peek("oor_dbg50", 7'h50, 32'h0);
        peek("oor_reg0", 7'd0, 32'h0);

        expect_frame(0, 16'd4, 1, 32'h0);
        xfer(1'b1, FRAME, mk(1'b0, 7'h50, 32'h0), -1, -1);

        expect_frame(0, 16'd5, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'd7, 32'h8000_0001), -1, -1);
        peek("wr_reg7", 7'd7, 32'h8000_0001);
        expect_frame(0, 16'd6, 1, 32'h8000_0001);
        xfer(1'b1, FRAME, mk(1'b0, 7'd7, 32'h0), -1, -1);

        expect_frame(1, 16'd6, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'd4, 32'h4444_4444), 15, -1);
        peek("seldrop_reg4", 7'd4, 32'h0);

`ifdef SPI_CFG_PARITY_EN
        expect_frame(1, 16'd6, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'd5, 32'h0000_0001) ^ 64'd1, -1, -1);
        peek("badpar_reg5", 7'd5, 32'h0);
        expect_frame(0, 16'd7, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'd5, 32'h0000_0001), -1, -1);
        peek("goodpar_reg5", 7'd5, 32'h1);
`endif

        xfer(1'b1, FRAME, mk(1'b1, 7'd6, 32'h6666_6666), 30, 30);
        check("midrst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        peek("midrst_reg6", 7'd6, 32'h0);
        peek("midrst_reg3", 7'd3, 32'h0);

        expect_frame(0, 16'd1, 0, 32'h0);
        xfer(1'b1, FRAME, mk(1'b1, 7'd6, 32'h0000_600D), -1, -1);
        peek("post_rst_reg6", 7'd6, 32'h0000_600D);

        waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cfg_responder.md
Name: spi_cfg_responder

Overview:
Chip-side SPI responder (slave) that decodes command/data frames driven by the WETOP SPI initiator on cs_b/clk_out/mosi and answers on miso. It holds a small configuration register file with readback, so initiator transactions can be checked against a known responder. It sits beside WETOP in the FPGA wrapper, and in the bench, and runs on the wrapper's system clock.

Parameters:
DATA_W, 32, data-phase width in bits.
ADDR_W, 7, address field width; command byte = {rw, addr}.
NREG, 8, implemented registers at addresses 0..NREG-1.
SYNC_STAGES, 2, synchronizer depth on cs_b, sclk and mosi.

Ports:
clk  in  1  system clock; must be at least 8x the sclk rate.
rst  in  1  synchronous, active-high reset.
spi_sel  in  1  responder enable; when 0, all SPI activity is ignored.
cs_b  in  1  chip select, active low.
sclk  in  1  SPI clock from the initiator (mode 0).
mosi  in  1  serial data in, MSB first.
miso  out  1  serial data out, MSB first.
dbg_addr  in  ADDR_W  combinational register-file peek address.
dbg_data  out  DATA_W  contents of reg[dbg_addr]; 0 if the address is out of range.
frame_done  out  1  one-cycle pulse for each valid completed frame.
frame_err  out  1  one-cycle pulse for each aborted or malformed frame.
frame_cnt  out  16  count of valid frames; wraps at 0xFFFF.

Behaviour:
- Synchronization: cs_b, sclk and mosi each pass through SYNC_STAGES flops. Rise/fall edges are detected on the synchronized sclk. Every action below occurs on the clk cycle the edge is detected.
- Reset values: all registers = 0, miso = 0, frame_done = 0, frame_err = 0, frame_cnt = 0, state = IDLE.
- Frame format: 1 rw bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. Total 40 bits with default parameters.
- State IDLE: waits for synchronized cs_b to fall while spi_sel = 1; then clears the bit counter and goes to CMD.
- State CMD: shifts mosi in on each sclk rise. After rise number 1+ADDR_W, latches rw/addr and goes to DATA.
- State DATA, read frames: on the first sclk fall in DATA, miso drives bit DATA_W-1 of reg[addr]. Each later fall shifts out the next lower bit. miso = 0 in all other states and phases. Out-of-range addresses read as 0.
- State DATA, write frames: shifts mosi in on each sclk rise.
- End of frame: cs_b rising with exactly 1+ADDR_W+DATA_W rises counted is a valid frame.
  - For a write with addr < NREG, reg[addr] is updated on that cycle.
  - Writes to addr >= NREG are dropped silently.
  - frame_done pulses and frame_cnt increments by 1.
  - State returns to IDLE.
- Error cases: frame_err pulses, no register write occurs, frame_cnt is unchanged, and state returns to IDLE. The error cases are:
  - cs_b rises with fewer rises than a full frame.
  - Extra sclk rises occur beyond the frame (overrun). The responder counts them and flags the error when cs_b rises.
  - spi_sel falls mid-frame.
- spi_sel = 0 in IDLE: cs_b and sclk are ignored and miso stays 0.
- sclk edges while cs_b is high are ignored.
- Back-to-back frames: cs_b low again on the cycle after returning to IDLE is accepted.
- Reset mid-frame: takes effect the next cycle; the frame is discarded with no write and no pulses.
- frame_done and frame_err are never asserted together.
- dbg_data is combinational and reflects a write on the cycle after the update.

Optional Feature:
SPI_CFG_PARITY_EN:
- When defined, one even-parity bit follows the data, giving a 41-bit frame with default parameters. Parity covers rw, addr and data.
- A write commits only if the parity matches; a mismatch gives frame_err with no write.
- For read frames, the responder drives the parity of its returned data on miso during the parity bit.
- When undefined, frames are 40 bits and there is no parity check.

Test Plan:
- Write addr 3, data 0xA5A5_1234, then read addr 3 -> miso returns 0xA5A5_1234 MSB first; dbg_data(3) = 0xA5A5_1234; frame_done pulses twice; frame_cnt = 2.
- Write frame aborted after 20 bits (cs_b high) -> frame_err for 1 cycle; reg[3] unchanged; frame_cnt unchanged.
- 41 sclk rises on a write to addr 1 -> frame_err; reg[1] stays 0.
- spi_sel = 0 during a full write to addr 2 -> no pulses, reg[2] = 0, miso = 0 throughout.
- Write to addr 0x50 (out of range) -> frame_done pulses, no register changes; a read of 0x50 returns 0.
- With SPI_CFG_PARITY_EN: a write to addr 5 of 0x0000_0001 with wrong parity -> frame_err and reg[5] = 0; with correct parity -> frame_done and reg[5] = 1.
